// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with EX-side operand forwarding for the 5-stage
//   MIPS pipeline. Captures the decoded ID-stage operands and controls every
//   cycle. Drives the ALU operand and control inputs with forwarded values.
//   Detects load-use hazards, stalls IF/ID and inserts a bubble into EX.
//
//   Optional feature: define ID_EX_PERF_EN to build the bubble and forwarding
//   performance counters. When it is undefined, no counter flops are built
//   and both counter outputs are tied to 0.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_valid                        ID slot holds a real instruction
//   id_rs, id_rt, id_rd             decoded register indices
//   id_rd1, id_rd2, id_imm          register-file data, sign-extended immediate
//   id_alu_ctrl, id_alu_src,
//   id_reg_dst                      ALU op, b-operand select, destination select
//   id_reg_write, id_mem_read,
//   id_mem_write, id_mem_to_reg     write-back / memory controls
//   flush                           branch/jump taken: kill the ID slot
//   mem_reg_write, mem_rd,
//   mem_fwd_data                    EX/MEM forwarding source
//   wb_reg_write, wb_rd,
//   wb_fwd_data                     MEM/WB forwarding source
//   stall_id                        hold PC and IF/ID (load-use hazard)
//   ula_a, ula_b, ula_control       ALU inputs after forwarding
//   ex_store_data                   forwarded rt value for stores
//   ex_write_reg                    selected destination register
//   ex_valid, ex_reg_write, ex_mem_read,
//   ex_mem_write, ex_mem_to_reg     registered controls
//   perf_bubbles, perf_fwd          performance counters
// ----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int DW     = 32,
   parameter int RW     = 5,
   parameter int CTRL_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [RW-1:0]     id_rs,
   input  logic [RW-1:0]     id_rt,
   input  logic [RW-1:0]     id_rd,
   input  logic [DW-1:0]     id_rd1,
   input  logic [DW-1:0]     id_rd2,
   input  logic [DW-1:0]     id_imm,
   input  logic [CTRL_W-1:0] id_alu_ctrl,
   input  logic              id_alu_src,
   input  logic              id_reg_dst,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   input  logic              flush,
   input  logic              mem_reg_write,
   input  logic [RW-1:0]     mem_rd,
   input  logic [DW-1:0]     mem_fwd_data,
   input  logic              wb_reg_write,
   input  logic [RW-1:0]     wb_rd,
   input  logic [DW-1:0]     wb_fwd_data,
   output logic              stall_id,
   output logic [DW-1:0]     ula_a,
   output logic [DW-1:0]     ula_b,
   output logic [CTRL_W-1:0] ula_control,
   output logic [DW-1:0]     ex_store_data,
   output logic [RW-1:0]     ex_write_reg,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg,
   output logic [31:0]       perf_bubbles,
   output logic [31:0]       perf_fwd
);

   // A producer matches a source only if it writes a non-zero register.
   function automatic logic fwd_hit(input logic we, input logic [RW-1:0] dst,
                                    input logic [RW-1:0] src);
      return we && (dst != '0) && (dst == src);
   endfunction

   // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
   function automatic logic [DW-1:0] fwd_sel(input logic mem_hit, input logic wb_hit,
                                             input logic [DW-1:0] mem_val,
                                             input logic [DW-1:0] wb_val,
                                             input logic [DW-1:0] rf_val);
      if (mem_hit)     return mem_val;
      else if (wb_hit) return wb_val;
      else             return rf_val;
   endfunction

   // ---- stage p0: ID-side decisions feeding the capture ----
   logic          bubble_p0;
   logic [RW-1:0] dest_p0;

   // ---- stage p1: ID/EX register contents ----
   logic              vld_p1;
   logic              reg_write_p1, mem_read_p1, mem_write_p1, mem_to_reg_p1;
   logic              alu_src_p1;
   logic [RW-1:0]     rs_p1, rt_p1, write_reg_p1;
   logic [DW-1:0]     rd1_p1, rd2_p1, imm_p1;
   logic [CTRL_W-1:0] alu_ctrl_p1;

   logic              mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;
   logic [DW-1:0]     fwd_a, fwd_b;

   // Load-use: the load in EX has not produced data yet, so ID must wait.
   // Deliberately independent of flush.
   assign stall_id  = vld_p1 & mem_read_p1 & (rt_p1 != '0) & id_valid &
                      ((rt_p1 == id_rs) | (rt_p1 == id_rt));
   assign bubble_p0 = flush | stall_id;
   assign dest_p0   = id_reg_dst ? id_rd : id_rt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1        <= 1'b0;
         reg_write_p1  <= 1'b0;
         mem_read_p1   <= 1'b0;
         mem_write_p1  <= 1'b0;
         mem_to_reg_p1 <= 1'b0;
         alu_src_p1    <= 1'b0;
         rs_p1         <= '0;
         rt_p1         <= '0;
         write_reg_p1  <= '0;
         rd1_p1        <= '0;
         rd2_p1        <= '0;
         imm_p1        <= '0;
         alu_ctrl_p1   <= '0;
      end else if (bubble_p0) begin
         // Bubble: data fields zeroed as well so rs/rt=0 never forward.
         vld_p1        <= 1'b0;
         reg_write_p1  <= 1'b0;
         mem_read_p1   <= 1'b0;
         mem_write_p1  <= 1'b0;
         mem_to_reg_p1 <= 1'b0;
         alu_src_p1    <= 1'b0;
         rs_p1         <= '0;
         rt_p1         <= '0;
         write_reg_p1  <= '0;
         rd1_p1        <= '0;
         rd2_p1        <= '0;
         imm_p1        <= '0;
         alu_ctrl_p1   <= '0;
      end else begin
         vld_p1        <= id_valid;
         reg_write_p1  <= id_valid & id_reg_write;
         mem_read_p1   <= id_valid & id_mem_read;
         mem_write_p1  <= id_valid & id_mem_write;
         mem_to_reg_p1 <= id_valid & id_mem_to_reg;
         alu_src_p1    <= id_alu_src;
         rs_p1         <= id_rs;
         rt_p1         <= id_rt;
         write_reg_p1  <= dest_p0;
         rd1_p1        <= id_rd1;
         rd2_p1        <= id_rd2;
         imm_p1        <= id_imm;
         alu_ctrl_p1   <= id_alu_ctrl;
      end
   end

   // ---- stage p1: forwarding and operand selection into the ALU ----
   assign mem_hit_a = fwd_hit(mem_reg_write, mem_rd, rs_p1);
   assign wb_hit_a  = fwd_hit(wb_reg_write, wb_rd, rs_p1);
   assign mem_hit_b = fwd_hit(mem_reg_write, mem_rd, rt_p1);
   assign wb_hit_b  = fwd_hit(wb_reg_write, wb_rd, rt_p1);

   assign fwd_a = fwd_sel(mem_hit_a, wb_hit_a, mem_fwd_data, wb_fwd_data, rd1_p1);
   assign fwd_b = fwd_sel(mem_hit_b, wb_hit_b, mem_fwd_data, wb_fwd_data, rd2_p1);

   assign ula_a         = fwd_a;
   assign ula_b         = alu_src_p1 ? imm_p1 : fwd_b;
   assign ula_control   = alu_ctrl_p1;
   assign ex_store_data = fwd_b;
   assign ex_write_reg  = write_reg_p1;
   assign ex_valid      = vld_p1;
   assign ex_reg_write  = reg_write_p1;
   assign ex_mem_read   = mem_read_p1;
   assign ex_mem_write  = mem_write_p1;
   assign ex_mem_to_reg = mem_to_reg_p1;

`ifdef ID_EX_PERF_EN
   logic [31:0] bub_cnt_p1, fwd_cnt_p1;

   // Counters wrap naturally modulo 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bub_cnt_p1 <= '0;
         fwd_cnt_p1 <= '0;
      end else begin
         if (bubble_p0)
            bub_cnt_p1 <= bub_cnt_p1 + 32'd1;
         if (vld_p1 && (mem_hit_a || wb_hit_a || mem_hit_b || wb_hit_b))
            fwd_cnt_p1 <= fwd_cnt_p1 + 32'd1;
      end
   end

   assign perf_bubbles = bub_cnt_p1;
   assign perf_fwd     = fwd_cnt_p1;
`else
   assign perf_bubbles = 32'd0;
   assign perf_fwd     = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage. A behavioural model holds the
//   instruction currently in EX; every falling edge the DUT outputs are
//   compared against it. Directed scenarios pin the model with literal values,
//   followed by a randomized stream.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rd1, id_rd2, id_imm;
   logic [2:0]  id_alu_ctrl;
   logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
   logic        flush;
   logic        mem_reg_write, wb_reg_write;
   logic [4:0]  mem_rd, wb_rd;
   logic [31:0] mem_fwd_data, wb_fwd_data;
   logic        stall_id;
   logic [31:0] ula_a, ula_b, ex_store_data;
   logic [2:0]  ula_control;
   logic [4:0]  ex_write_reg;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
   logic [31:0] perf_bubbles, perf_fwd;

   int checks   = 0;
   int failures = 0;
   logic cmp_en = 1'b0;

   id_ex_stage #(.DW(32), .RW(5), .CTRL_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
      .flush(flush),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_fwd_data(mem_fwd_data),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_fwd_data(wb_fwd_data),
      .stall_id(stall_id), .ula_a(ula_a), .ula_b(ula_b), .ula_control(ula_control),
      .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
      .perf_bubbles(perf_bubbles), .perf_fwd(perf_fwd)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        valid;
      logic [4:0]  rs, rt, dest;
      logic [31:0] rd1, rd2, imm;
      logic [2:0]  ctrl;
      logic        alu_src, reg_write, mem_read, mem_write, mem_to_reg;
   } ex_t;

   ex_t         m;
   logic [31:0] m_bub, m_fwd;

   function automatic logic m_stall();
      return m.valid && m.mem_read && m.rt != 5'd0 && id_valid &&
             (m.rt == id_rs || m.rt == id_rt);
   endfunction

   function automatic logic m_hit(input logic [4:0] src);
      return (mem_reg_write && mem_rd != 5'd0 && mem_rd == src) ||
             (wb_reg_write && wb_rd != 5'd0 && wb_rd == src);
   endfunction

   function automatic logic [31:0] m_val(input logic [4:0] src, input logic [31:0] rf);
      if (mem_reg_write && mem_rd != 5'd0 && mem_rd == src) return mem_fwd_data;
      if (wb_reg_write && wb_rd != 5'd0 && wb_rd == src)    return wb_fwd_data;
      return rf;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m     = '0;
         m_bub = 32'd0;
         m_fwd = 32'd0;
      end else begin
         if (m.valid && (m_hit(m.rs) || m_hit(m.rt))) m_fwd = m_fwd + 32'd1;
         if (flush || m_stall()) begin
            m     = '0;
            m_bub = m_bub + 32'd1;
         end else begin
            m.valid      = id_valid;
            m.rs         = id_rs;
            m.rt         = id_rt;
            m.dest       = id_reg_dst ? id_rd : id_rt;
            m.rd1        = id_rd1;
            m.rd2        = id_rd2;
            m.imm        = id_imm;
            m.ctrl       = id_alu_ctrl;
            m.alu_src    = id_alu_src;
            m.reg_write  = id_valid && id_reg_write;
            m.mem_read   = id_valid && id_mem_read;
            m.mem_write  = id_valid && id_mem_write;
            m.mem_to_reg = id_valid && id_mem_to_reg;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_stall_id", 64'(stall_id), 64'(m_stall()));
         chk("m_ula_a", 64'(ula_a), 64'(m_val(m.rs, m.rd1)));
         chk("m_ula_b", 64'(ula_b), 64'(m.alu_src ? m.imm : m_val(m.rt, m.rd2)));
         chk("m_store", 64'(ex_store_data), 64'(m_val(m.rt, m.rd2)));
         chk("m_ctrl", 64'(ula_control), 64'(m.ctrl));
         chk("m_wreg", 64'(ex_write_reg), 64'(m.dest));
         chk("m_valid", 64'(ex_valid), 64'(m.valid));
         chk("m_ctl_bits", 64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
             64'({m.reg_write, m.mem_read, m.mem_write, m.mem_to_reg}));
`ifdef ID_EX_PERF_EN
         chk("m_perf_bub", 64'(perf_bubbles), 64'(m_bub));
         chk("m_perf_fwd", 64'(perf_fwd), 64'(m_fwd));
`else
         chk("m_perf_tied", 64'({perf_bubbles, perf_fwd}), 64'd0);
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic id_idle();
      id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
      id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_alu_ctrl = 0;
      id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
      id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0; flush = 0;
   endtask

   task automatic fwd_idle();
      mem_reg_write = 0; mem_rd = 0; mem_fwd_data = 0;
      wb_reg_write = 0; wb_rd = 0; wb_fwd_data = 0;
   endtask

   task automatic set_instr(input logic [4:0] rs, rt, rd, input logic [31:0] d1, d2, imm,
                            input logic [2:0] ctrl, input logic asrc, rdst, rw, mr, mw, mtr);
      id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
      id_rd1 = d1; id_rd2 = d2; id_imm = imm; id_alu_ctrl = ctrl;
      id_alu_src = asrc; id_reg_dst = rdst; id_reg_write = rw;
      id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = mtr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] pb0;

   initial begin
      rst_n = 0;
      id_idle();
      fwd_idle();
      cmp_en = 1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      tick();

      // add $3,$1,$2 : rd1=5, rd2=7
      set_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h99, 3'b010, 0, 1, 1, 0, 0, 0);
      tick();
      id_idle();
      @(negedge clk);
      chk("add_ula_a", 64'(ula_a), 64'd5);
      chk("add_ula_b", 64'(ula_b), 64'd7);
      chk("add_ctrl", 64'(ula_control), 64'd2);
      chk("add_wreg", 64'(ex_write_reg), 64'd3);
      chk("add_valid", 64'(ex_valid), 64'd1);

      // EX/MEM and MEM/WB both target rs=1
      tick();
      set_instr(5'd1, 5'd2, 5'd5, 32'h11, 32'h22, 32'h0, 3'b010, 0, 1, 1, 0, 0, 0);
      tick();
      id_idle();
      mem_reg_write = 1; mem_rd = 5'd1; mem_fwd_data = 32'hAA;
      wb_reg_write = 1;  wb_rd = 5'd1;  wb_fwd_data = 32'hBB;
      @(negedge clk);
      chk("fwd_mem_prio", 64'(ula_a), 64'hAA);
      #1 mem_reg_write = 0;
      #1 chk("fwd_wb", 64'(ula_a), 64'hBB);
      fwd_idle();
      #1 chk("fwd_none", 64'(ula_a), 64'h11);

      // register 0 never forwarded
      tick();
      set_instr(5'd0, 5'd0, 5'd8, 32'h1234, 32'h5678, 32'h0, 3'b010, 0, 1, 1, 0, 0, 0);
      tick();
      id_idle();
      mem_reg_write = 1; mem_rd = 5'd0; mem_fwd_data = 32'hFFFF_FFFF;
      wb_reg_write = 1;  wb_rd = 5'd0;  wb_fwd_data = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("r0_ula_a", 64'(ula_a), 64'h1234);
      chk("r0_store", 64'(ex_store_data), 64'h5678);
      fwd_idle();

      // lw $4 then a dependent add: one stall, one bubble
      tick();
      set_instr(5'd2, 5'd4, 5'd0, 32'h0, 32'h0, 32'h10, 3'b010, 1, 0, 1, 1, 0, 1);
      tick();
      pb0 = perf_bubbles;
      set_instr(5'd4, 5'd6, 5'd7, 32'h40, 32'h60, 32'h0, 3'b010, 0, 1, 1, 0, 0, 0);
      @(negedge clk);
      chk("lu_stall", 64'(stall_id), 64'd1);
      tick();
      @(negedge clk);
      chk("lu_bubble", 64'(ex_valid), 64'd0);
      chk("lu_stall_drop", 64'(stall_id), 64'd0);
`ifdef ID_EX_PERF_EN
      chk("lu_perf", 64'(perf_bubbles - pb0), 64'd1);
`endif
      tick();
      id_idle();
      @(negedge clk);
      chk("lu_capture", 64'(ex_valid), 64'd1);
      chk("lu_wreg", 64'(ex_write_reg), 64'd7);

      // flush coincident with stall: a single bubble
      tick();
      set_instr(5'd2, 5'd4, 5'd0, 32'h0, 32'h0, 32'h10, 3'b010, 1, 0, 1, 1, 0, 1);
      tick();
      pb0 = perf_bubbles;
      set_instr(5'd4, 5'd6, 5'd9, 32'h40, 32'h60, 32'h0, 3'b110, 0, 1, 1, 0, 0, 0);
      flush = 1;
      @(negedge clk);
      chk("fs_stall", 64'(stall_id), 64'd1);
      tick();
      flush = 0;
      @(negedge clk);
      chk("fs_bubble", 64'(ex_valid), 64'd0);
`ifdef ID_EX_PERF_EN
      chk("fs_perf", 64'(perf_bubbles - pb0), 64'd1);
`endif
      tick();
      id_idle();
      @(negedge clk);
      chk("fs_capture", 64'(ex_valid), 64'd1);
      chk("fs_wreg", 64'(ex_write_reg), 64'd9);

      // asynchronous reset in the middle of a stall
      tick();
      set_instr(5'd2, 5'd4, 5'd0, 32'h0, 32'h0, 32'h10, 3'b011, 1, 0, 1, 1, 0, 1);
      tick();
      set_instr(5'd4, 5'd6, 5'd7, 32'h40, 32'h60, 32'h0, 3'b010, 0, 1, 1, 0, 0, 0);
      @(negedge clk);
      chk("rst_pre_stall", 64'(stall_id), 64'd1);
      #2 rst_n = 0;
      #1;
      chk("rst_valid", 64'(ex_valid), 64'd0);
      chk("rst_stall", 64'(stall_id), 64'd0);
      chk("rst_ctrl", 64'(ula_control), 64'd0);
      chk("rst_perf", 64'({perf_bubbles, perf_fwd}), 64'd0);
      tick();
      id_idle();
      @(negedge clk);
      rst_n = 1;

      // randomized stream
      repeat (2000) begin
         tick();
         id_valid      = ($urandom_range(0, 9) < 8);
         id_rs         = 5'($urandom_range(0, 7));
         id_rt         = 5'($urandom_range(0, 7));
         id_rd         = 5'($urandom_range(0, 7));
         id_rd1        = $urandom;
         id_rd2        = $urandom;
         id_imm        = $urandom;
         id_alu_ctrl   = 3'($urandom_range(0, 7));
         id_alu_src    = 1'($urandom_range(0, 1));
         id_reg_dst    = 1'($urandom_range(0, 1));
         id_reg_write  = 1'($urandom_range(0, 1));
         id_mem_read   = ($urandom_range(0, 9) < 3);
         id_mem_write  = 1'($urandom_range(0, 1));
         id_mem_to_reg = 1'($urandom_range(0, 1));
         flush         = ($urandom_range(0, 9) == 0);
         mem_reg_write = 1'($urandom_range(0, 1));
         mem_rd        = 5'($urandom_range(0, 7));
         mem_fwd_data  = $urandom;
         wb_reg_write  = 1'($urandom_range(0, 1));
         wb_rd         = 5'($urandom_range(0, 7));
         wb_fwd_data   = $urandom;
      end
      tick();
      @(negedge clk);
      cmp_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
